// File: rtl/timer_pkg.sv
// Shared types and helpers for the interval timer: FSM state, divider math,
// and the Morse front-end timing constants expressed in ticks.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Clock cycles per tick.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Prescaler counter width, never narrower than one bit.
  function automatic int calc_pre_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  // Morse element lengths in ticks at the default 1 kHz tick rate.
  localparam int DOT_TICKS        = 60;
  localparam int DASH_TICKS       = 3 * DOT_TICKS;
  localparam int SYMBOL_GAP_TICKS = DOT_TICKS;
  localparam int LETTER_GAP_TICKS = 3 * DOT_TICKS;
  localparam int WORD_GAP_TICKS   = 7 * DOT_TICKS;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter that pauses on enable=0 and reports a
// single-cycle wrap indication on the cycle it rolls from DIV-1 back to 0.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic wrap
);

  localparam int PW = calc_pre_w(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    // clear beats enable so a restart never leaks a wrap from the old run
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer: prescaled tick stream plus a period counter
// with one-shot or periodic timeout; all outputs come straight from flops.
module interval_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic             oneshot,
  output logic             tick,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] elapsed
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

  generate
    if (TICK_HZ <= 0 || (CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
      $error("interval_timer: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             oneshot_q, oneshot_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             tick_q, tick_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             pre_clear, pre_wrap;
  logic [CNT_W-1:0] elapsed_inc;

  // Any start or stop resets the prescaler phase; in IDLE it is held at 0.
  assign pre_clear   = start | stop | (state_q != RUN);
  assign elapsed_inc = elapsed_q + CNT_W'(1);

  tick_prescaler #(.DIV(DIV)) u_pre (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (pre_clear),
    .wrap   (pre_wrap)
  );

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    oneshot_d = oneshot_q;
    elapsed_d = elapsed_q;
    tick_d    = 1'b0;
    timeout_d = 1'b0;
    if (start) begin
      elapsed_d = '0;
      if (period != '0) begin
        state_d   = RUN;
        period_d  = period;
        oneshot_d = oneshot;
      end else begin
        state_d = IDLE;
      end
    end else if (stop) begin
      state_d   = IDLE;
      elapsed_d = '0;
    end else if (state_q == RUN && pre_wrap) begin
      tick_d = 1'b1;
      // elapsed stays below period, so the increment can never overflow
      if (elapsed_inc == period_q) begin
        timeout_d = 1'b1;
        elapsed_d = '0;
        if (oneshot_q) state_d = IDLE;
      end else begin
        elapsed_d = elapsed_inc;
      end
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      period_q  <= '0;
      oneshot_q <= 1'b0;
      elapsed_q <= '0;
      tick_q    <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      oneshot_q <= oneshot_d;
      elapsed_q <= elapsed_d;
      tick_q    <= tick_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign tick    = tick_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;
  assign elapsed = elapsed_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with DIV=10, CNT_W=4; expected pulse
// times are hand-derived from the start edge (rel counts edges after it).
module tb_interval_timer;

  logic       clk = 1'b0;
  logic       rst, enable, start, stop, oneshot;
  logic [3:0] period;
  logic       tick, timeout, busy;
  logic [3:0] elapsed;

  int n_cmp = 0, n_bad = 0;
  int rel, tick_n, to_n;

  interval_timer #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop),
    .period(period), .oneshot(oneshot),
    .tick(tick), .timeout(timeout), .busy(busy), .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int r);
    while (rel < r) begin
      step();
      rel++;
      if (tick)    tick_n++;
      if (timeout) to_n++;
    end
  endtask

  task automatic do_start(input logic [3:0] p, input logic os);
    period  = p;
    oneshot = os;
    start   = 1'b1;
    step();
    start   = 1'b0;
    rel = 0; tick_n = 0; to_n = 0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0;
    oneshot = 1'b0; period = 4'd0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_elapsed", elapsed, 0);

    // 1: one-shot, period 3
    do_start(4'd3, 1'b1);
    chk("t1_busy0", busy, 1);
    run_to(9);   chk("t1_tick9", tick, 0); chk("t1_tickn9", tick_n, 0);
    run_to(10);  chk("t1_tick10", tick, 1); chk("t1_el10", elapsed, 1);
    run_to(20);  chk("t1_tick20", tick, 1); chk("t1_el20", elapsed, 2);
    run_to(29);  chk("t1_to_n29", to_n, 0); chk("t1_busy29", busy, 1);
    run_to(30);  chk("t1_tick30", tick, 1); chk("t1_to30", timeout, 1);
    chk("t1_busy30", busy, 0); chk("t1_el30", elapsed, 0);
    run_to(130); chk("t1_tickn", tick_n, 3); chk("t1_to_n", to_n, 1);

    // 2: periodic, period 2; period input changed mid-run must be ignored
    do_start(4'd2, 1'b0);
    period = 4'd7; oneshot = 1'b1;
    run_to(10); chk("t2_el10", elapsed, 1);
    run_to(20); chk("t2_to20", timeout, 1); chk("t2_el20", elapsed, 0); chk("t2_busy20", busy, 1);
    run_to(30); chk("t2_el30", elapsed, 1);
    run_to(40); chk("t2_to40", timeout, 1);
    run_to(60); chk("t2_to60", timeout, 1);
    chk("t2_to_n", to_n, 3); chk("t2_tickn", tick_n, 6); chk("t2_busy60", busy, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t2_stop_busy", busy, 0);

    // 3: pause for 7 edges after rel 5
    do_start(4'd2, 1'b1);
    run_to(5); enable = 1'b0;
    run_to(12); enable = 1'b1;
    chk("t3_tickn12", tick_n, 0); chk("t3_el12", elapsed, 0);
    run_to(16); chk("t3_tick16", tick, 0);
    run_to(17); chk("t3_tick17", tick, 1); chk("t3_el17", elapsed, 1);
    run_to(26); chk("t3_to_n26", to_n, 0);
    run_to(27); chk("t3_to27", timeout, 1); chk("t3_busy27", busy, 0);

    // 4a: restart at rel 35 with period 1
    do_start(4'd5, 1'b1);
    run_to(34);
    do_start(4'd1, 1'b1);
    run_to(9);  chk("t4_to_n9", to_n, 0);
    run_to(10); chk("t4_to10", timeout, 1);
    run_to(15); chk("t4_to15", timeout, 0); chk("t4_to_n", to_n, 1);

    // 4b: stop on the would-be timeout edge
    do_start(4'd2, 1'b1);
    run_to(19); stop = 1'b1;
    run_to(20); stop = 1'b0;
    chk("t4_stop_to", timeout, 0); chk("t4_stop_tick", tick, 0);
    chk("t4_stop_busy", busy, 0); chk("t4_stop_to_n", to_n, 0);

    // 4c: restart on the would-be timeout edge
    do_start(4'd2, 1'b0);
    run_to(19);
    do_start(4'd3, 1'b0);
    chk("t4_rs_to", timeout, 0); chk("t4_rs_tick", tick, 0);
    chk("t4_rs_busy", busy, 1); chk("t4_rs_el", elapsed, 0);

    // start and stop together: start wins
    stop = 1'b1;
    do_start(4'd2, 1'b1);
    stop = 1'b0;
    chk("t4_ss_busy", busy, 1);

    // 5: period 0 ignored, period 15 max
    stop = 1'b1; step(); stop = 1'b0;
    do_start(4'd0, 1'b1);
    chk("t5_p0_busy", busy, 0);
    run_to(30); chk("t5_p0_tickn", tick_n, 0);
    do_start(4'd15, 1'b1);
    run_to(149); chk("t5_to_n149", to_n, 0); chk("t5_el149", elapsed, 14);
    run_to(150); chk("t5_to150", timeout, 1); chk("t5_el150", elapsed, 0);
    chk("t5_busy150", busy, 0); chk("t5_tickn", tick_n, 15);

    // start with enable low: load now, count once enable rises
    enable = 1'b0;
    do_start(4'd1, 1'b1);
    run_to(5); chk("t5_en0_busy", busy, 1); chk("t5_en0_el", elapsed, 0);
    enable = 1'b1;
    run_to(14); chk("t5_en0_to_n", to_n, 0);
    run_to(15); chk("t5_en0_to", timeout, 1);

    // 6: reset mid-run on edge 13
    do_start(4'd3, 1'b0);
    run_to(12); rst = 1'b1;
    run_to(13); rst = 1'b0;
    chk("t6_busy", busy, 0); chk("t6_el", elapsed, 0);
    chk("t6_tick", tick, 0); chk("t6_to", timeout, 0);
    rel = 0; tick_n = 0; to_n = 0;
    run_to(50); chk("t6_quiet_tick", tick_n, 0); chk("t6_quiet_to", to_n, 0);
    do_start(4'd1, 1'b0);
    run_to(10); chk("t6_resume_to", timeout, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
